// File: rtl/point_add_arbiter.sv
// point_add_arbiter: round-robin sharing of one point-add core between NUM_REQ requesters,
// with registered operands, start/finished handshake, and a watchdog abort.
module point_add_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W       = 255,
  parameter int TIMEOUT = 4095
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_doubling,
  input  logic [NUM_REQ*W-1:0]        i_x1,
  input  logic [NUM_REQ*W-1:0]        i_y1,
  input  logic [NUM_REQ*W-1:0]        i_z1,
  input  logic [NUM_REQ*W-1:0]        i_x2,
  input  logic [NUM_REQ*W-1:0]        i_y2,
  input  logic [NUM_REQ*W-1:0]        i_z2,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [NUM_REQ-1:0]          o_done,
  output logic                        o_timeout,
  output logic [W-1:0]                o_x3,
  output logic [W-1:0]                o_y3,
  output logic [W-1:0]                o_z3,
  output logic                        o_busy,
  output logic [$clog2(NUM_REQ)-1:0]  o_owner,
  output logic                        o_pa_start,
  output logic                        o_pa_doubling,
  output logic [W-1:0]                o_pa_x1,
  output logic [W-1:0]                o_pa_y1,
  output logic [W-1:0]                o_pa_z1,
  output logic [W-1:0]                o_pa_x2,
  output logic [W-1:0]                o_pa_y2,
  output logic [W-1:0]                o_pa_z2,
  input  logic [W-1:0]                i_pa_x3,
  input  logic [W-1:0]                i_pa_y3,
  input  logic [W-1:0]                i_pa_z3,
  input  logic                        i_pa_finished
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                    state_q, state_d;
  logic [OW-1:0]             rr_q, rr_d, owner_q, owner_d, pick, cand;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      timeout_q, timeout_d, dbl_q, dbl_d, found;
  logic [5:0][W-1:0]         op_q, op_d;
  logic [2:0][W-1:0]         res_q, res_d;
  logic [5:0][NUM_REQ*W-1:0] in_ops;
  int                        idx;
  assign in_ops = {i_z2, i_y2, i_x2, i_z1, i_y1, i_x1};
  // first requesting index at or after the round-robin pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx  = int'(rr_q) + i;
      idx  = idx >= NUM_REQ ? idx - NUM_REQ : idx;
      cand = OW'(idx);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      dbl_q     <= 1'b0;
      op_q      <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      dbl_q     <= dbl_d;
      op_q      <= op_d;
      res_q     <= res_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    dbl_d     = dbl_q;
    op_d      = op_q;
    res_d     = res_q;
    case (state_q)
      IDLE: if (found) begin
        owner_d = pick;
        dbl_d   = i_doubling[pick];
        for (int j = 0; j < 6; j++) op_d[j] = in_ops[j][pick*W +: W];
        state_d = ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(~&timer_q);
        if (i_pa_finished) begin
          res_d     = {i_pa_z3, i_pa_y3, i_pa_x3};
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_d     = '0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        rr_d    = owner_q == OW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    o_gnt          = '0;
    o_done         = '0;
    o_gnt[owner_q]  = state_q == ISSUE;
    o_done[owner_q] = state_q == RESP;
    o_pa_start     = state_q == ISSUE;
    o_timeout      = state_q == RESP && timeout_q;
    o_busy         = state_q != IDLE;
    o_owner        = owner_q;
    o_pa_doubling  = dbl_q;
    o_pa_x1        = op_q[0];
    o_pa_y1        = op_q[1];
    o_pa_z1        = op_q[2];
    o_pa_x2        = op_q[3];
    o_pa_y2        = op_q[4];
    o_pa_z2        = op_q[5];
    o_x3           = res_q[0];
    o_y3           = res_q[1];
    o_z3           = res_q[2];
  end
endmodule

// File: tb/tb_point_add_arbiter.sv
// tb_point_add_arbiter: directed stimulus, cycle-indexed transaction model checked every cycle,
// plus literal expectations for grant/done timing and results.
module tb_point_add_arbiter;
  localparam int N = 2, W = 255, TO = 24;
  logic i_clk = 0, i_rst = 1;
  logic [N-1:0] i_req = '0, i_doubling = '0;
  logic [N*W-1:0] i_x1 = '0, i_y1 = '0, i_z1 = '0, i_x2 = '0, i_y2 = '0, i_z2 = '0;
  logic [N-1:0] o_gnt, o_done;
  logic o_timeout, o_busy, o_pa_start, o_pa_doubling;
  logic [0:0] o_owner;
  logic [W-1:0] o_x3, o_y3, o_z3, o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2;
  logic [W-1:0] i_pa_x3 = '0, i_pa_y3 = '0, i_pa_z3 = '0;
  logic core_fin = 0, man_fin = 0, i_pa_finished;
  assign i_pa_finished = core_fin | man_fin;
  always #5 i_clk = ~i_clk;
  point_add_arbiter #(.NUM_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_doubling(i_doubling),
    .i_x1(i_x1), .i_y1(i_y1), .i_z1(i_z1), .i_x2(i_x2), .i_y2(i_y2), .i_z2(i_z2),
    .o_gnt(o_gnt), .o_done(o_done), .o_timeout(o_timeout),
    .o_x3(o_x3), .o_y3(o_y3), .o_z3(o_z3), .o_busy(o_busy), .o_owner(o_owner),
    .o_pa_start(o_pa_start), .o_pa_doubling(o_pa_doubling),
    .o_pa_x1(o_pa_x1), .o_pa_y1(o_pa_y1), .o_pa_z1(o_pa_z1),
    .o_pa_x2(o_pa_x2), .o_pa_y2(o_pa_y2), .o_pa_z2(o_pa_z2),
    .i_pa_x3(i_pa_x3), .i_pa_y3(i_pa_y3), .i_pa_z3(i_pa_z3), .i_pa_finished(i_pa_finished)
  );
  int nvec = 0, nerr = 0, cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask
  // core model: finishes core_lat cycles after the start pulse (0 = never)
  int core_lat = 0, fin_at = -1;
  always @(negedge i_clk) if (o_pa_start && core_lat > 0) fin_at = cyc + core_lat;
  always @(posedge i_clk) begin
    #1;
    core_fin = core_lat > 0 && cyc == fin_at;
  end
  // model: op accepted at cycle m_a, decided at m_e; gnt at m_a+1, done at m_e+1
  bit m_act = 0, m_to = 0, m_dbl = 0;
  int m_a = -10, m_e = -1, m_own = 0, m_rr = 0;
  logic [W-1:0] m_op [6];
  logic [W-1:0] m_res [3];
  int gnt_cnt = 0, done_cnt = 0, last_gnt = 0, last_done = 0;
  int gnt_q[$];
  logic [W-1:0] px_q[$];
  logic [W-1:0] cap_x, cap_y, cap_z;
  logic cap_to, dbl_cap;
  always @(negedge i_clk) begin
    logic [N-1:0] eg, ed;
    bit got;
    if (!i_rst) begin
      m_act = 0; m_to = 0; m_dbl = 0; m_rr = 0; m_own = 0; m_a = -10; m_e = -1;
      for (int j = 0; j < 6; j++) m_op[j] = '0;
      for (int j = 0; j < 3; j++) m_res[j] = '0;
    end
    eg = '0;
    ed = '0;
    if (m_act && cyc == m_a + 1) eg[m_own] = 1'b1;
    if (m_act && m_e >= 0 && cyc == m_e + 1) ed[m_own] = 1'b1;
    chk("gnt", o_gnt, eg);
    chk("done", o_done, ed);
    chk("start", o_pa_start, |eg);
    chk("timeout", o_timeout, (|ed) && m_to);
    chk("busy", o_busy, m_act);
    chk("owner", o_owner, m_own);
    chk("pa_dbl", o_pa_doubling, m_dbl);
    chk("pa_x1", o_pa_x1, m_op[0]); chk("pa_y1", o_pa_y1, m_op[1]); chk("pa_z1", o_pa_z1, m_op[2]);
    chk("pa_x2", o_pa_x2, m_op[3]); chk("pa_y2", o_pa_y2, m_op[4]); chk("pa_z2", o_pa_z2, m_op[5]);
    chk("x3", o_x3, m_res[0]); chk("y3", o_y3, m_res[1]); chk("z3", o_z3, m_res[2]);
    if (|o_gnt) begin
      gnt_cnt++; last_gnt = cyc; gnt_q.push_back(o_gnt[1] ? 1 : 0);
      px_q.push_back(o_pa_x1); dbl_cap = o_pa_doubling;
    end
    if (|o_done) begin
      done_cnt++; last_done = cyc;
      cap_x = o_x3; cap_y = o_y3; cap_z = o_z3; cap_to = o_timeout;
    end
    if (i_rst) begin
      if (!m_act) begin
        got = 0;
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_rr + i) % N;
          if (!got && i_req[k]) begin
            got = 1; m_act = 1; m_a = cyc; m_e = -1; m_own = k; m_dbl = i_doubling[k];
            m_op[0] = i_x1[k*W +: W]; m_op[1] = i_y1[k*W +: W]; m_op[2] = i_z1[k*W +: W];
            m_op[3] = i_x2[k*W +: W]; m_op[4] = i_y2[k*W +: W]; m_op[5] = i_z2[k*W +: W];
          end
        end
      end else if (m_e < 0 && cyc >= m_a + 2) begin
        if (i_pa_finished) begin
          m_e = cyc; m_to = 0; m_res[0] = i_pa_x3; m_res[1] = i_pa_y3; m_res[2] = i_pa_z3;
        end else if (cyc == m_a + 1 + TO) begin
          m_e = cyc; m_to = 1; m_res[0] = '0; m_res[1] = '0; m_res[2] = '0;
        end
      end else if (m_e >= 0 && cyc == m_e + 1) begin
        m_rr = (m_own + 1) % N;
        m_act = 0;
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask
  task automatic wait_gnt(input int max);
    int s, k;
    s = gnt_cnt; k = 0;
    while (gnt_cnt == s && k < max) begin tick(1); k++; end
    if (gnt_cnt == s) begin nvec++; nerr++; $display("FAIL wait_gnt: no grant within %0d cycles", max); end
  endtask
  task automatic wait_done(input int max);
    int s, k;
    s = done_cnt; k = 0;
    while (done_cnt == s && k < max) begin tick(1); k++; end
    if (done_cnt == s) begin nvec++; nerr++; $display("FAIL wait_done: no done within %0d cycles", max); end
  endtask
  task automatic set_ops(input int k, input int a, b, c, d, e, f, input bit dbl);
    i_x1[k*W +: W] = W'(a); i_y1[k*W +: W] = W'(b); i_z1[k*W +: W] = W'(c);
    i_x2[k*W +: W] = W'(d); i_y2[k*W +: W] = W'(e); i_z2[k*W +: W] = W'(f);
    i_doubling[k] = dbl;
  endtask
  task automatic set_res(input int x, y, z);
    i_pa_x3 = W'(x); i_pa_y3 = W'(y); i_pa_z3 = W'(z);
  endtask
  initial begin
    int t, g, dc;
    #1 i_rst = 0;
    tick(3);
    i_rst = 1;
    tick(2);
    // single requester, core answers 20 cycles after start
    set_ops(0, 9, 5, 1, 4, 7, 1, 0); set_res(11, 22, 33); core_lat = 20;
    i_req[0] = 1; t = cyc;
    wait_gnt(10); i_req[0] = 0;
    chk("t1_gnt_cycle", last_gnt, t + 1);
    chk("t1_pa_x1", px_q[$], 9);
    wait_done(60);
    chk("t1_done_cycle", last_done, t + 22);
    chk("t1_x3", cap_x, 11); chk("t1_y3", cap_y, 22); chk("t1_z3", cap_z, 33);
    chk("t1_to", cap_to, 0);
    // both requesters held: pointer is 1 after owner 0, so 1,0,1,0
    tick(1);
    gnt_q.delete(); px_q.delete();
    set_ops(0, 100, 101, 102, 103, 104, 105, 0);
    set_ops(1, 200, 201, 202, 203, 204, 205, 1);
    set_res(44, 45, 46); core_lat = 3; i_req = 2'b11;
    repeat (4) wait_done(60);
    i_req = '0;
    chk("t2_ngnt", gnt_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", gnt_q[i], (i % 2 == 0) ? 1 : 0);
      chk("t2_px1", px_q[i], (i % 2 == 0) ? 200 : 100);
    end
    // watchdog abort, then a normal op
    tick(1);
    core_lat = 0; set_ops(0, 7, 8, 9, 10, 11, 12, 0); i_req[0] = 1;
    wait_gnt(10); g = last_gnt; i_req[0] = 0;
    wait_done(TO + 20);
    chk("t3_done_cycle", last_done, g + TO + 1);
    chk("t3_to", cap_to, 1);
    chk("t3_x3", cap_x, 0); chk("t3_y3", cap_y, 0); chk("t3_z3", cap_z, 0);
    core_lat = 5; set_res(55, 56, 57); set_ops(1, 1, 2, 3, 4, 5, 6, 0); i_req[1] = 1;
    wait_gnt(10); i_req[1] = 0;
    chk("t3b_owner", gnt_q[$], 1);
    wait_done(40);
    chk("t3b_to", cap_to, 0); chk("t3b_x3", cap_x, 55);
    // stray finished in IDLE and in ISSUE is ignored
    tick(1);
    core_lat = 0; dc = done_cnt;
    man_fin = 1; tick(1); man_fin = 0; tick(1);
    chk("t4_idle_done", done_cnt, dc);
    chk("t4_idle_busy", o_busy, 0);
    set_res(66, 67, 68); set_ops(0, 21, 22, 23, 24, 25, 26, 0);
    i_req[0] = 1; t = cyc;
    tick(1); man_fin = 1;
    tick(1); man_fin = 0; i_req[0] = 0;
    tick(4); man_fin = 1;
    tick(1); man_fin = 0;
    wait_done(10);
    chk("t4_done_cycle", last_done, t + 7);
    chk("t4_ndone", done_cnt, dc + 1);
    chk("t4_x3", cap_x, 66); chk("t4_to", cap_to, 0);
    // asynchronous reset mid-WAIT
    tick(1);
    set_ops(0, 77, 78, 79, 80, 81, 82, 0); i_req[0] = 1;
    wait_gnt(10); i_req[0] = 0;
    tick(3); dc = done_cnt;
    #2 i_rst = 0;
    #1;
    chk("t5_busy", o_busy, 0); chk("t5_gnt", o_gnt, 0); chk("t5_done", o_done, 0);
    chk("t5_start", o_pa_start, 0); chk("t5_x3", o_x3, 0); chk("t5_pa_x1", o_pa_x1, 0);
    chk("t5_owner", o_owner, 0); chk("t5_to", o_timeout, 0);
    tick(2);
    core_lat = 4; i_rst = 1; set_ops(1, 90, 91, 92, 93, 94, 95, 0); i_req[1] = 1; t = cyc;
    wait_gnt(10); i_req[1] = 0;
    chk("t5_gnt_cycle", last_gnt, t + 1);
    chk("t5_gnt_owner", gnt_q[$], 1);
    chk("t5_no_done", done_cnt, dc);
    wait_done(20);
    chk("t5_done_to", cap_to, 0);
    // doubling, finished lands on the timeout cycle
    tick(1);
    set_ops(1, 31, 32, 33, 34, 35, 36, 1); set_res(81, 82, 83); core_lat = TO; i_req[1] = 1;
    wait_gnt(10); g = last_gnt; i_req[1] = 0;
    chk("t6_dbl", dbl_cap, 1);
    wait_done(TO + 20);
    chk("t6_done_cycle", last_done, g + TO + 1);
    chk("t6_to", cap_to, 0);
    chk("t6_x3", cap_x, 81); chk("t6_y3", cap_y, 82); chk("t6_z3", cap_z, 83);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
